ccff_chain_loader: RTL and testbench

Configuration-chain driver for the fabric's `ccff_head` → `ccff_tail` scan path (LUT truth tables and routing-mux SRAM bits in each logic tile). It accepts the bitstream as a valid/ready word stream, serialises it onto `ccff_head`, and emits a shift enable that gates the chain's clock. A verify pass re-shifts the same bitstream and compares the returning `ccff_tail` bits against the bits being sent.

---
 rtl/ccff_loader_pkg.sv | 16 +
 rtl/ccff_word_serializer.sv | 84 ++++++++
 rtl/ccff_chain_loader.sv | 122 ++++++++++++
 tb/tb_ccff_chain_loader.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_loader_pkg.sv
// Shared types and helpers for the configuration-chain loader.
//   state_t   : loader FSM states
//   words_for : number of input words needed to cover a chain of len bits
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  function automatic int unsigned words_for(input int unsigned len, input int unsigned w);
    return (len + w - 1) / w;
  endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Word buffer for the configuration chain loader. Accepts bitstream words on
// a valid/ready handshake and presents them one bit at a time, LSB first.
// The final word of a pass is truncated so exactly CHAIN_LEN bits are issued.
//   prog_clk, reset   : clock, synchronous active-high reset
//   enable            : loader is in its shift state (words may be taken)
//   clear             : new pass starting, restart the word count
//   s_data/s_valid    : input word stream
//   s_ready           : word accepted on s_valid && s_ready
//   consume           : current bit is being shifted this cycle
//   bit_data          : current bit
//   bit_valid         : buffer holds a bit
//   last_bit_of_word  : current bit is the last one needed from this word
module ccff_word_serializer
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 18,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              consume,
  output logic              bit_data,
  output logic              bit_valid,
  output logic              last_bit_of_word
);

  localparam int NUM_WORDS = words_for(CHAIN_LEN, WORD_W);
  localparam int REM       = CHAIN_LEN % WORD_W;
  localparam int LAST_IDX  = (REM == 0) ? WORD_W - 1 : REM - 1;
  localparam int IW        = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int WCW       = $clog2(NUM_WORDS + 1);

  logic [WORD_W-1:0] buf_q;
  logic [IW-1:0]     idx_q;
  logic              full_q;
  logic [WCW-1:0]    wc_q;
  logic              final_word;
  logic              load;

  // Once every word of the pass has been taken, the buffer holds the final
  // (possibly truncated) word and no further words are accepted.
  assign final_word       = (wc_q == WCW'(NUM_WORDS));
  assign bit_valid        = full_q;
  assign bit_data         = buf_q[0];
  assign last_bit_of_word = full_q &&
                            (idx_q == (final_word ? IW'(LAST_IDX) : IW'(WORD_W - 1)));

  // Ready while empty, or while the last bit of a word leaves, so that words
  // can follow each other with no bubble.
  assign s_ready = enable && (full_q ? (last_bit_of_word && consume && !final_word)
                                     : !final_word);
  assign load    = s_valid && s_ready;

  always_ff @(posedge prog_clk) begin
    if (reset) begin
      buf_q  <= '0;
      idx_q  <= '0;
      full_q <= 1'b0;
      wc_q   <= '0;
    end else if (clear) begin
      idx_q  <= '0;
      full_q <= 1'b0;
      wc_q   <= '0;
    end else if (load) begin
      buf_q  <= s_data;
      idx_q  <= '0;
      full_q <= 1'b1;
      wc_q   <= wc_q + WCW'(1);
    end else if (consume && full_q) begin
      if (last_bit_of_word) begin
        full_q <= 1'b0;
      end else begin
        buf_q <= buf_q >> 1;
        idx_q <= idx_q + IW'(1);
      end
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// Configuration-chain driver. Serialises a word stream onto ccff_head with a
// matching shift enable for the chain's clock gate. A verify pass re-shifts
// the bitstream and compares the bits returning on ccff_tail.
//   prog_clk, reset  : clock, synchronous active-high reset
//   start, verify    : begin a pass (verify=1 compares while reloading)
//   s_data/s_valid/s_ready : bitstream word stream, LSB first
//   ccff_head/ccff_tail    : chain serial in / out
//   chain_shift_en   : chain advances at the edge ending a cycle with this high
//   busy, done       : pass in progress / one-cycle end-of-pass pulse
//   error            : sticky verify mismatch flag, cleared by start
//   mismatch_cnt     : mismatches seen in the last verify pass
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 18,
  parameter int WORD_W    = 8
) (
  input  logic                           prog_clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           verify,
  input  logic [WORD_W-1:0]              s_data,
  input  logic                           s_valid,
  output logic                           s_ready,
  output logic                           ccff_head,
  input  logic                           ccff_tail,
  output logic                           chain_shift_en,
  output logic                           busy,
  output logic                           done,
  output logic                           error,
  output logic [$clog2(CHAIN_LEN+1)-1:0] mismatch_cnt
);

  localparam int CW = $clog2(CHAIN_LEN + 1);

  state_t        state_q;
  logic          verify_q;
  logic [CW-1:0] bit_cnt_q;
  logic          last_shift_q;
  logic          ser_bit;
  logic          ser_valid;
  logic          ser_last;
  logic          consume;
  logic          final_issue;

  assign consume     = (state_q == ST_SHIFT) && ser_valid;
  assign final_issue = consume && ser_last && (bit_cnt_q == CW'(CHAIN_LEN - 1));

  ccff_word_serializer #(
    .CHAIN_LEN (CHAIN_LEN),
    .WORD_W    (WORD_W)
  ) u_ser (
    .prog_clk         (prog_clk),
    .reset            (reset),
    .enable           (state_q == ST_SHIFT),
    .clear            ((state_q == ST_IDLE) && start),
    .s_data           (s_data),
    .s_valid          (s_valid),
    .s_ready          (s_ready),
    .consume          (consume),
    .bit_data         (ser_bit),
    .bit_valid        (ser_valid),
    .last_bit_of_word (ser_last)
  );

  // ccff_head/chain_shift_en are the registered image of the serializer bit,
  // so the physical shift happens the cycle after a bit is consumed. The pass
  // ends once that final registered shift has been driven.
  always_ff @(posedge prog_clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      verify_q       <= 1'b0;
      bit_cnt_q      <= '0;
      last_shift_q   <= 1'b0;
      ccff_head      <= 1'b0;
      chain_shift_en <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      mismatch_cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q      <= ST_SHIFT;
            verify_q     <= verify;
            bit_cnt_q    <= '0;
            last_shift_q <= 1'b0;
            mismatch_cnt <= '0;
            error        <= 1'b0;
            busy         <= 1'b1;
          end
        end
        ST_SHIFT: begin
          chain_shift_en <= consume;
          last_shift_q   <= final_issue;
          if (consume) begin
            ccff_head <= ser_bit;
            bit_cnt_q <= bit_cnt_q + CW'(1);
          end
          // Tail is sampled before the shift edge: it carries the bit that
          // was loaded at the same position on the previous pass.
          if (chain_shift_en && verify_q && (ccff_tail != ccff_head)) begin
            error        <= 1'b1;
            mismatch_cnt <= mismatch_cnt + CW'(1);
          end
          if (last_shift_q) begin
            state_q <= ST_DONE;
            done    <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy    <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
module tb_ccff_chain_loader;
  localparam int L  = 18;
  localparam int W  = 8;
  localparam int MW = $clog2(L + 1);

  logic          prog_clk = 1'b0;
  logic          reset, start, verify, s_valid;
  logic [W-1:0]  s_data;
  logic          s_ready, ccff_head, ccff_tail, chain_shift_en, busy, done, error;
  logic [MW-1:0] mismatch_cnt;

  typedef struct {
    logic [L-1:0] chain;
    int           mm;
    logic         err;
    int           shift_base;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   total_shifts = 0;
  int   done_cnt = 0;
  logic [L-1:0] chain_m = '0;   // behavioural chain, bit 0 nearest the tail
  logic [L-1:0] cur_chain = '0; // expected chain contents after last pass

  ccff_chain_loader #(.CHAIN_LEN(L), .WORD_W(W)) dut (
    .prog_clk       (prog_clk),
    .reset          (reset),
    .start          (start),
    .verify         (verify),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .ccff_head      (ccff_head),
    .ccff_tail      (ccff_tail),
    .chain_shift_en (chain_shift_en),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .mismatch_cnt   (mismatch_cnt)
  );

  always #5 prog_clk = ~prog_clk;

  assign ccff_tail = chain_m[0];

  always @(posedge prog_clk) begin
    if (chain_shift_en) begin
      chain_m      <= {ccff_head, chain_m[L-1:1]};
      total_shifts <= total_shifts + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rst_vals();
    chk("rst_s_ready", s_ready, 0);
    chk("rst_head", ccff_head, 0);
    chk("rst_shift_en", chain_shift_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_mismatch_cnt", mismatch_cnt, 0);
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send_word(input logic [W-1:0] w);
    int n = 0;
    s_data  = w;
    s_valid = 1'b1;
    while (!s_ready && n < 100) begin
      @(negedge prog_clk);
      n++;
    end
    chk("handshake", s_ready, 1);
    @(negedge prog_clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_done(input bit start_done, input int done_base);
    int   n = 0;
    exp_t e;
    while (!done && n < 300) begin
      @(negedge prog_clk);
      n++;
    end
    chk("done_seen", done, 1);
    chk("sb_depth", sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("chain", chain_m, e.chain);
      chk("mismatch_cnt", mismatch_cnt, e.mm);
      chk("error", error, e.err);
      chk("shift_count", total_shifts - e.shift_base, L);
    end
    if (start_done) begin
      start  = 1'b1;
      verify = 1'b1;
    end
    @(negedge prog_clk);
    start  = 1'b0;
    verify = 1'b0;
    chk("done_one_cycle", done, 0);
    chk("busy_after_done", busy, 0);
    chk("done_pulses", done_cnt - done_base, 1);
  endtask

  task automatic run_pass(input logic v, input logic [W-1:0] w0, input logic [W-1:0] w1,
                          input logic [W-1:0] w2, input int stall, input bit start_mid,
                          input bit start_done);
    logic [3*W-1:0] cat;
    exp_t           e;
    int             dbase;
    int             n;
    logic           hold;
    cat     = {w2, w1, w0};
    e.chain = cat[L-1:0];
    e.mm    = v ? $countones(cat[L-1:0] ^ cur_chain) : 0;
    e.err   = (e.mm != 0);
    @(negedge prog_clk);
    start        = 1'b1;
    verify       = v;
    e.shift_base = total_shifts;
    dbase        = done_cnt;
    sb.push_back(e);
    cur_chain    = cat[L-1:0];
    @(negedge prog_clk);
    start  = 1'b0;
    verify = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_s_ready", s_ready, 1);
    chk("start_error_clr", error, 0);
    chk("start_mm_clr", mismatch_cnt, 0);
    chk("start_no_shift", chain_shift_en, 0);
    send_word(w0);
    if (start_mid) begin
      start  = 1'b1;
      verify = ~v;
      @(negedge prog_clk);
      start  = 1'b0;
      verify = 1'b0;
      chk("mid_start_busy", busy, 1);
    end
    if (stall > 0) begin
      n = 0;
      while (!s_ready && n < 50) begin
        @(negedge prog_clk);
        n++;
      end
      chk("stall_ready", s_ready, 1);
      @(negedge prog_clk);
      hold = ccff_head;
      chk("stall_hold_bit", hold, w0[W-1]);
      repeat (stall - 1) begin
        @(negedge prog_clk);
        chk("stall_shift_en", chain_shift_en, 0);
        chk("stall_head", ccff_head, hold);
      end
      send_word(w1);
      chk("stall_shift_en", chain_shift_en, 0);
      chk("stall_head", ccff_head, hold);
    end else begin
      send_word(w1);
    end
    send_word(w2);
    wait_done(start_done, dbase);
  endtask

  initial begin
    int n;
    int dbase;
    int base;
    reset   = 1'b1;
    start   = 1'b1;   // start coincident with reset must lose
    verify  = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    repeat (3) @(negedge prog_clk);
    chk_rst_vals();
    reset  = 1'b0;
    start  = 1'b0;
    verify = 1'b0;
    @(negedge prog_clk);
    chk_rst_vals();

    run_pass(1'b0, 8'hA5, 8'h3C, 8'h02, 0, 1'b0, 1'b0);  // load
    run_pass(1'b1, 8'hA5, 8'h3C, 8'h02, 0, 1'b0, 1'b0);  // verify match
    run_pass(1'b1, 8'hA4, 8'h3C, 8'h02, 0, 1'b0, 1'b0);  // verify, one mismatch
    run_pass(1'b0, 8'hA5, 8'h3C, 8'h02, 5, 1'b0, 1'b0);  // load with stall
    run_pass(1'b1, 8'hA5, 8'h3C, 8'h02, 0, 1'b1, 1'b1);  // ignored starts

    // reset in the middle of a pass
    @(negedge prog_clk);
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    dbase = done_cnt;
    base  = total_shifts;
    send_word(8'hA5);
    send_word(8'h3C);
    n = 0;
    while ((total_shifts - base) < 9 && n < 100) begin
      @(negedge prog_clk);
      n++;
    end
    chk("mid_shifts", total_shifts - base, 9);
    reset = 1'b1;
    @(negedge prog_clk);
    chk_rst_vals();
    reset = 1'b0;
    repeat (3) @(negedge prog_clk);
    chk("no_done_after_reset", done_cnt - dbase, 0);
    chk("idle_after_reset", busy, 0);

    run_pass(1'b0, 8'hA5, 8'h3C, 8'h02, 0, 1'b0, 1'b0);  // reload after abort
    run_pass(1'b1, 8'h5A, 8'hC3, 8'h01, 0, 1'b0, 1'b0);  // every bit mismatches

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
